// File: rtl/types_pkg.sv
// Shared types for the rename/dispatch boundary.
package types_pkg;
    typedef struct packed {
        logic [1:0]  fu;       // 0=ALU, 1=BR, 2=LSU
        logic [5:0]  tag;
        logic [15:0] payload;
    } rename_data;
endpackage

// File: rtl/dispatch_ctrl_if.sv
// Rename -> dispatch -> RS/ROB handshake bundle.
interface dispatch_ctrl_if #(parameter int NUM_RS = 3);
    import types_pkg::*;

    logic              rn_valid;
    rename_data        rn_data;
    logic              rn_ready;
    logic [NUM_RS-1:0] rs_full;
    logic [NUM_RS-1:0] rs_di_en;
    rename_data        di_data;
    logic              rob_full;
    logic              rob_alloc;

    modport master (
        output rn_valid, rn_data, rs_full, rob_full,
        input  rn_ready, rs_di_en, di_data, rob_alloc
    );

    modport slave (
        input  rn_valid, rn_data, rs_full, rob_full,
        output rn_ready, rs_di_en, di_data, rob_alloc
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: one-entry skid register steering renamed ops to RS by FU class,
// with ROB/RS back-pressure, mispredict blackout and saturating stall counters.
module dispatch_ctrl
    import types_pkg::*;
#(
    parameter int NUM_RS       = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    dispatch_ctrl_if.slave   dif,
    input  logic             mispredict,
    output logic             flushing,
    output logic             bad_fu,
    output logic [CNT_W-1:0] stall_rob_cnt,
    output logic [CNT_W-1:0] stall_rs_cnt
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

    state_t            state_q, state_d;
    logic [2:0]        fcnt_q, fcnt_d;
    rename_data        hold_q;
    logic              hold_vld_q;

    logic              run;
    logic              fu_ok;
    logic              rs_blk;
    logic              fire;
    logic              drop;
    logic              rdy;
    logic              stall;
    logic [NUM_RS-1:0] en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Steering: a mispredict in a RUN cycle kills the held op before it can strobe.
    always_comb begin
        run    = (state_q == RUN);
        fu_ok  = (int'(hold_q.fu) < NUM_RS);
        rs_blk = 1'b0;
        for (int i = 0; i < NUM_RS; i++)
            if (int'(hold_q.fu) == i) rs_blk = dif.rs_full[i];
        fire   = run && !mispredict && hold_vld_q && fu_ok && !dif.rob_full && !rs_blk;
        drop   = run && !mispredict && hold_vld_q && !fu_ok;
        stall  = run && !mispredict && hold_vld_q && fu_ok && !fire;
        rdy    = reset && run && !mispredict && (!hold_vld_q || fire || drop);
        en     = '0;
        for (int i = 0; i < NUM_RS; i++)
            if (int'(hold_q.fu) == i) en[i] = fire;
    end

    assign dif.rs_di_en  = en;
    assign dif.rob_alloc = fire;
    assign dif.di_data   = hold_q;
    assign dif.rn_ready  = rdy;
    assign bad_fu        = drop;

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        flushing = 1'b0;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LD;
                end
            end
            FLUSH: begin
                flushing = 1'b1;
                if (mispredict) begin
                    fcnt_d = FLUSH_LD;
                end else if (fcnt_q <= 3'd1) begin
                    state_d = RUN;
                    fcnt_d  = 3'd0;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else if (run && mispredict) begin
            hold_vld_q <= 1'b0;
        end else if (dif.rn_valid && rdy) begin
            hold_vld_q <= 1'b1;
            hold_q     <= dif.rn_data;
        end else if (fire || drop) begin
            hold_vld_q <= 1'b0;
        end
    end

    // ROB-full takes priority when both ROB and the target RS are full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_rob_cnt <= '0;
            stall_rs_cnt  <= '0;
        end else if (stall) begin
            if (dif.rob_full) stall_rob_cnt <= sat_inc(stall_rob_cnt);
            else              stall_rs_cnt  <= sat_inc(stall_rs_cnt);
        end
    end

    a_one_strobe: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(dif.rs_di_en) && (dif.rob_alloc == (|dif.rs_di_en)));

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: queue scoreboard of dispatched ops plus directed back-pressure,
// flush, bad-FU and reset scenarios.
module tb_dispatch_ctrl;
    import types_pkg::*;

    localparam int NUM_RS = 3;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             mispredict;
    logic             flushing;
    logic             bad_fu;
    logic [CNT_W-1:0] stall_rob_cnt;
    logic [CNT_W-1:0] stall_rs_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int n_push  = 0;
    int n_disp  = 0;
    rename_data sb_q[$];

    dispatch_ctrl_if #(.NUM_RS(NUM_RS)) dif();

    dispatch_ctrl #(.NUM_RS(NUM_RS), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .dif           (dif.slave),
        .mispredict    (mispredict),
        .flushing      (flushing),
        .bad_fu        (bad_fu),
        .stall_rob_cnt (stall_rob_cnt),
        .stall_rs_cnt  (stall_rs_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic rename_data mk(input logic [1:0] fu, input logic [5:0] tag);
        rename_data d;
        d.fu      = fu;
        d.tag     = tag;
        d.payload = 16'hC000 | {10'd0, tag};
        return d;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input rename_data d);
        sb_q.push_back(d);
        n_push++;
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected op.
    always @(negedge clk) begin
        if (reset && (dif.rob_alloc || (dif.rs_di_en != '0))) begin
            rename_data e;
            logic [NUM_RS-1:0] exp_en;
            n_disp++;
            if (sb_q.size() == 0) begin
                chk("spurious_dispatch", 32'(dif.rs_di_en), 32'd0);
            end else begin
                e = sb_q.pop_front();
                exp_en = '0;
                exp_en[e.fu] = 1'b1;
                chk("di_data", 32'(dif.di_data), 32'(e));
                chk("rs_di_en", 32'(dif.rs_di_en), 32'(exp_en));
                chk("rob_alloc", 32'(dif.rob_alloc), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] fus [4];
        int nfl;
        fus = '{2'd0, 2'd1, 2'd2, 2'd0};

        reset          = 1'b0;
        mispredict     = 1'b0;
        dif.rn_valid   = 1'b0;
        dif.rn_data    = '0;
        dif.rs_full    = '0;
        dif.rob_full   = 1'b0;
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("rst_rn_ready", 32'(dif.rn_ready), 32'd0);
        chk("rst_rs_di_en", 32'(dif.rs_di_en), 32'd0);
        chk("rst_rob_alloc", 32'(dif.rob_alloc), 32'd0);
        chk("rst_flushing", 32'(flushing), 32'd0);
        chk("rst_di_data", 32'(dif.di_data), 32'd0);
        next_cyc();
        reset = 1'b1;
        next_cyc();

        // 4-op back-to-back stream
        for (int i = 0; i < 4; i++) begin
            dif.rn_valid = 1'b1;
            dif.rn_data  = mk(fus[i], 6'(i + 1));
            @(negedge clk);
            chk("stream_rdy", 32'(dif.rn_ready), 32'd1);
            if (i > 0) chk("stream_alloc", 32'(dif.rob_alloc), 32'd1);
            if (dif.rn_ready) push(dif.rn_data);
            next_cyc();
        end
        dif.rn_valid = 1'b0;
        @(negedge clk);
        chk("stream_alloc_last", 32'(dif.rob_alloc), 32'd1);
        next_cyc();
        @(negedge clk);
        chk("stream_idle", 32'(dif.rob_alloc), 32'd0);
        next_cyc();

        // RS-full stall on LSU for 5 cycles
        dif.rn_valid = 1'b1;
        dif.rn_data  = mk(2'd2, 6'd10);
        dif.rs_full  = 3'b100;
        @(negedge clk);
        push(dif.rn_data);
        next_cyc();
        dif.rn_data = mk(2'd0, 6'd11);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rsfull_rdy", 32'(dif.rn_ready), 32'd0);
            chk("rsfull_en", 32'(dif.rs_di_en), 32'd0);
            next_cyc();
        end
        dif.rn_valid = 1'b0;
        dif.rs_full  = 3'b000;
        @(negedge clk);
        chk("rsfull_cnt", 32'(stall_rs_cnt), 32'd5);
        chk("rsfull_release", 32'(dif.rs_di_en), 32'b100);
        next_cyc();

        // ROB full and all RS full: counted as ROB stalls only
        dif.rn_valid = 1'b1;
        dif.rn_data  = mk(2'd1, 6'd12);
        dif.rob_full = 1'b1;
        dif.rs_full  = 3'b111;
        @(negedge clk);
        push(dif.rn_data);
        next_cyc();
        dif.rn_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("robfull_alloc", 32'(dif.rob_alloc), 32'd0);
            next_cyc();
        end
        dif.rob_full = 1'b0;
        dif.rs_full  = 3'b000;
        @(negedge clk);
        chk("robfull_cnt", 32'(stall_rob_cnt), 32'd3);
        chk("robfull_rs_cnt", 32'(stall_rs_cnt), 32'd5);
        next_cyc();

        // Held op killed by mispredict; 2-cycle blackout
        dif.rn_valid = 1'b1;
        dif.rn_data  = mk(2'd0, 6'd20);
        @(negedge clk);
        chk("mp_load_rdy", 32'(dif.rn_ready), 32'd1);
        next_cyc();
        mispredict  = 1'b1;
        dif.rn_data = mk(2'd1, 6'd21);
        @(negedge clk);
        chk("mp_rdy", 32'(dif.rn_ready), 32'd0);
        chk("mp_alloc", 32'(dif.rob_alloc), 32'd0);
        chk("mp_flushing", 32'(flushing), 32'd0);
        next_cyc();
        mispredict = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("flush_on", 32'(flushing), 32'd1);
            chk("flush_rdy", 32'(dif.rn_ready), 32'd0);
            next_cyc();
        end
        @(negedge clk);
        chk("flush_off", 32'(flushing), 32'd0);
        chk("resume_rdy", 32'(dif.rn_ready), 32'd1);
        if (dif.rn_ready) push(dif.rn_data);
        next_cyc();
        dif.rn_valid = 1'b0;
        next_cyc();

        // Second mispredict on first FLUSH cycle
        nfl = 0;
        mispredict = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            nfl += int'(flushing);
            next_cyc();
            if (c == 1) mispredict = 1'b0;
        end
        chk("flush_ext_len", 32'(nfl), 32'd3);

        // Illegal FU is dropped, next op dispatches
        dif.rn_valid = 1'b1;
        dif.rn_data  = mk(2'd3, 6'd30);
        @(negedge clk);
        chk("badfu_load_rdy", 32'(dif.rn_ready), 32'd1);
        next_cyc();
        dif.rn_data = mk(2'd2, 6'd31);
        @(negedge clk);
        chk("badfu_pulse", 32'(bad_fu), 32'd1);
        chk("badfu_alloc", 32'(dif.rob_alloc), 32'd0);
        chk("badfu_rdy", 32'(dif.rn_ready), 32'd1);
        if (dif.rn_ready) push(dif.rn_data);
        next_cyc();
        dif.rn_valid = 1'b0;
        @(negedge clk);
        chk("badfu_once", 32'(bad_fu), 32'd0);
        next_cyc();

        // Saturate ROB stall counter, then reset mid-FLUSH
        dif.rn_valid = 1'b1;
        dif.rn_data  = mk(2'd1, 6'd40);
        dif.rob_full = 1'b1;
        next_cyc();
        dif.rn_valid = 1'b0;
        repeat (300) next_cyc();
        @(negedge clk);
        chk("sat_rob_cnt", 32'(stall_rob_cnt), 32'hFF);
        next_cyc();
        mispredict = 1'b1;
        next_cyc();
        mispredict = 1'b0;
        @(negedge clk);
        chk("pre_rst_flushing", 32'(flushing), 32'd1);
        #2;
        reset = 1'b0;
        #2;
        chk("arst_flushing", 32'(flushing), 32'd0);
        chk("arst_rob_cnt", 32'(stall_rob_cnt), 32'd0);
        chk("arst_rs_cnt", 32'(stall_rs_cnt), 32'd0);
        chk("arst_rdy", 32'(dif.rn_ready), 32'd0);
        chk("arst_alloc", 32'(dif.rob_alloc), 32'd0);
        chk("arst_di_data", 32'(dif.di_data), 32'd0);
        dif.rob_full = 1'b0;
        next_cyc();
        reset = 1'b1;
        dif.rn_valid = 1'b1;
        dif.rn_data  = mk(2'd0, 6'd50);
        @(negedge clk);
        chk("post_rst_flushing", 32'(flushing), 32'd0);
        chk("post_rst_rdy", 32'(dif.rn_ready), 32'd1);
        if (dif.rn_ready) push(dif.rn_data);
        next_cyc();
        dif.rn_valid = 1'b0;
        repeat (3) next_cyc();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("disp_total", 32'(n_disp), 32'd9);
        chk("push_total", 32'(n_push), 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
